// File: rtl/modulo_r_down_counter_pkg.sv
// Shared constants and the width-check helper for the modulo-R counter family.
package modulo_r_down_counter_pkg;
  localparam int DEFAULT_R     = 10;
  localparam int DEFAULT_WIDTH = 4;

  // True when modulus r is legal and r-1 fits in w bits.
  function automatic bit width_ok(input int r, input int w);
    return (r >= 2) && ($clog2(r) <= w);
  endfunction
endpackage

// File: rtl/modulo_r_down_counter_if.sv
// Enable/load/qout handshake shared by the modulo-R up and down counters.
interface modulo_r_down_counter_if
  import modulo_r_down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] qout;
  logic             bout;
  logic             zero;
  logic             load_err;

  modport master (output enable, load, din, input qout, bout, zero, load_err);
  modport slave  (input enable, load, din, output qout, bout, zero, load_err);
endinterface

// File: rtl/modulo_r_down_counter.sv
// Loadable modulo-R down counter; bout is the borrow into the next, more significant stage.
module modulo_r_down_counter
  import modulo_r_down_counter_pkg::*;
#(
  parameter int R     = DEFAULT_R,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  modulo_r_down_counter_if.slave   bus
);
  localparam logic [WIDTH-1:0] RMAX = WIDTH'(R - 1);

  if (!width_ok(R, WIDTH)) begin : g_bad_params
    $error("modulo_r_down_counter: need R >= 2 and 2**WIDTH >= R");
  end

  logic [WIDTH-1:0] qout_q, qout_d;
  logic             load_err_q, load_err_d;
  logic             zero;

  assign zero = (qout_q == '0);

  always_comb begin
    qout_d     = qout_q;
    load_err_d = 1'b0;
    if (bus.load) begin
      // Out-of-range loads clamp to the top of the range and flag it for one cycle.
      if (bus.din > RMAX) begin
        qout_d     = RMAX;
        load_err_d = 1'b1;
      end else begin
        qout_d = bus.din;
      end
    end else if (bus.enable) begin
      qout_d = zero ? RMAX : qout_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      qout_q     <= '0;
      load_err_q <= 1'b0;
    end else begin
      qout_q     <= qout_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.qout     = qout_q;
  assign bus.zero     = zero;
  assign bus.bout     = bus.enable & zero;
  assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_modulo_r_down_counter.sv
// Directed bench for modulo_r_down_counter (R=10, WIDTH=4), including a two-digit cascade.
module tb_modulo_r_down_counter;
  localparam int R = 10;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  modulo_r_down_counter_if #(.WIDTH(W)) if0 ();
  modulo_r_down_counter_if #(.WIDTH(W)) if1 ();

  // Upper digit: enabled by the lower digit's borrow, shares load.
  assign if1.enable = if0.bout;
  assign if1.load   = if0.load;

  modulo_r_down_counter #(.R(R), .WIDTH(W)) u0 (.clk(clk), .reset(reset), .bus(if0));
  modulo_r_down_counter #(.R(R), .WIDTH(W)) u1 (.clk(clk), .reset(reset), .bus(if1));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int exp_q;
    int bout_cnt;

    reset = 1'b1; if0.enable = 1'b1; if0.load = 1'b0; if0.din = '0; if1.din = '0;
    tick(); tick();
    check("rst_qout", 32'(if0.qout), 0);
    check("rst_zero", 32'(if0.zero), 1);
    check("rst_bout", 32'(if0.bout), 1);
    check("rst_err",  32'(if0.load_err), 0);

    // Free-running countdown: 9,8,...,0,9,... ; borrow exactly at qout==0
    reset = 1'b0;
    bout_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_q = (R - (k % R)) % R;
      check("count_qout", 32'(if0.qout), 32'(exp_q));
      check("count_bout", 32'(if0.bout), (exp_q == 0) ? 1 : 0);
      if (if0.bout) bout_cnt++;
    end
    check("bout_twice", 32'(bout_cnt), 2);

    // Load beats enable
    if0.load = 1'b1; if0.din = 4'd6;
    tick();
    check("load6_qout", 32'(if0.qout), 6);
    check("load6_err",  32'(if0.load_err), 0);
    if0.load = 1'b0;
    tick(); check("after_load_5", 32'(if0.qout), 5);
    tick(); check("after_load_4", 32'(if0.qout), 4);

    // Out-of-range load clamps and pulses load_err once
    if0.load = 1'b1; if0.din = 4'd13;
    tick();
    check("clamp_qout", 32'(if0.qout), 9);
    check("clamp_err",  32'(if0.load_err), 1);
    if0.load = 1'b0; if0.enable = 1'b0;
    tick();
    check("clamp_hold", 32'(if0.qout), 9);
    check("err_pulse_end", 32'(if0.load_err), 0);

    // Reset beats load
    reset = 1'b1; if0.load = 1'b1; if0.din = 4'd4;
    tick();
    check("rst_load_qout", 32'(if0.qout), 0);
    if0.din = 4'd13;
    tick();
    check("rst_badload_qout", 32'(if0.qout), 0);
    check("rst_badload_err",  32'(if0.load_err), 0);
    check("rst_zero_no_en",   32'(if0.zero), 1);
    check("rst_bout_no_en",   32'(if0.bout), 0);

    // Load with enable low, then hold
    reset = 1'b0; if0.din = 4'd3;
    tick(); check("load3", 32'(if0.qout), 3);
    if0.load = 1'b0;
    tick(); check("hold3_a", 32'(if0.qout), 3);
    tick(); check("hold3_b", 32'(if0.qout), 3);

    // Enable gap from 7: 1,0,0,1 -> 6,6,6,5 with no borrow
    if0.load = 1'b1; if0.din = 4'd7;
    tick(); check("load7", 32'(if0.qout), 7);
    if0.load = 1'b0;
    if0.enable = 1'b1; tick(); check("gap_q1", 32'(if0.qout), 6); check("gap_b1", 32'(if0.bout), 0);
    if0.enable = 1'b0; tick(); check("gap_q2", 32'(if0.qout), 6); check("gap_b2", 32'(if0.bout), 0);
    tick();                    check("gap_q3", 32'(if0.qout), 6); check("gap_b3", 32'(if0.bout), 0);
    if0.enable = 1'b1; tick(); check("gap_q4", 32'(if0.qout), 5); check("gap_b4", 32'(if0.bout), 0);

    // Load 0 while enabled: borrow asserts immediately after
    if0.load = 1'b1; if0.din = 4'd0;
    tick();
    check("load0_qout", 32'(if0.qout), 0);
    check("load0_bout", 32'(if0.bout), 1);
    if0.load = 1'b0;
    tick(); check("load0_wrap", 32'(if0.qout), 9);

    // Two-digit cascade: 00, 99, 98, ...
    if0.enable = 1'b0; if0.load = 1'b1; if0.din = 4'd0; if1.din = 4'd0;
    tick();
    check("casc_init", 32'(if1.qout) * 10 + 32'(if0.qout), 0);
    if0.load = 1'b0; if0.enable = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      check("casc_val", 32'(if1.qout) * 10 + 32'(if0.qout), 32'((100 - k) % 100));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/modulo_r_down_counter.md
# modulo_r_down_counter

Loadable modulo-R down counter with a borrow output. It is the decrementing counterpart of the existing modulo-R up counter. It shares that block's enable/qout handshake, so the two can sit side by side in counter chains. Its main uses are countdown timers and cascaded down-counting digits. Several instances chain through `bout` → `enable` of the next, more significant stage.

## Interface
Parameters:
- `R`, default 10: modulus, ≥ 2; count range is 0 … R-1.
- `WIDTH`, default 4: width of `qout` and `din`; must satisfy 2^WIDTH ≥ R.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `enable`  input  1  count enable; one decrement per enabled cycle.
- `load`  input  1  synchronous parallel load strobe.
- `din`  input  WIDTH  load value.
- `qout`  output  WIDTH  current count, registered.
- `bout`  output  1  borrow; combinational, high when `enable` = 1 and `qout` = 0.
- `zero`  output  1  combinational, high when `qout` = 0, independent of `enable`.
- `load_err`  output  1  registered; high for one cycle after a load with `din` ≥ R.

## Operation
- Priority at each rising edge of `clk`: `reset` > `load` > `enable` > hold.
- **Reset:** `qout` ← 0 and `load_err` ← 0. Because `zero` and `bout` are derived from `qout`, `zero` = 1 and `bout` follows `enable` in the cycle after reset.
- **Load:**
  - If `din` < R, then `qout` ← `din` and `load_err` ← 0.
  - If `din` ≥ R, then `qout` ← R-1 (clamped) and `load_err` ← 1.
  - `enable` is ignored in a load cycle; load wins.
- **Count:** when `enable` = 1 and no load, `qout` ← `qout` - 1.
  - Wrap-around: at `qout` = 0, the next value is R-1, not 2^WIDTH - 1.
- **Hold:** when `enable` = 0 and no load, `qout` is unchanged.
- **`load_err`:** cleared on any cycle without an out-of-range load, so it is exactly a one-cycle pulse.
- **Width rule:** decrement is computed at WIDTH bits; the zero test is done before the subtraction, so no WIDTH+1 borrow is needed.
- **No-FSM:** the block is a single state register (`qout`) plus the `load_err` flag; no other hidden state.
- **Cascading:** `bout` of stage k drives `enable` of stage k+1. All stages share `clk`, `reset` and `load`.

## Timing
- Latency: `qout` reflects reset, load or decrement one clock after the qualifying edge.
- `bout` and `zero` are combinational from `qout` (and `enable`, for `bout`). They are valid in the same cycle, with no added register stage.
- `enable` held high gives a full sequence of R cycles: 0, R-1, R-2, …, 1, 0.
  - `bout` is high in exactly one of those R cycles, the one in which `qout` = 0.
- **Simultaneous `reset` and `load`:** reset wins; `qout` = 0 and `load_err` = 0.
- **Load of 0 with `enable` = 1:** `qout` = 0 next cycle, and `bout` then asserts because `enable` is still high.
- **Reset mid-count:** takes effect on the next edge regardless of `qout`; no partial state survives.
- `enable` toggling has no memory; a gap simply holds the count.

## Structure
- Shared package/header holds:
  - the default modulus constant (10) and default width (4);
  - a width-check macro or function used for `$clog2(R)` ≤ WIDTH elaboration checks, also used by the up counter.
- Elaboration-time assertion: R ≥ 2 and 2^WIDTH ≥ R.
- No sub-module inside the stage.
- One natural wrapper for system use is `cascaded_down_counter`: N instances of `modulo_r_down_counter` chained by `bout` → `enable`. It is outside this block's scope and is verified separately.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `enable` = 1 → `qout` = 0, `zero` = 1, `bout` = 1, `load_err` = 0. Release with `enable` = 1 → `qout` sequence 9, 8, …, 0, 9.
- **Full countdown (R = 10):** `enable` = 1 for 20 cycles → `bout` high exactly twice, on the cycles where `qout` = 0. `qout` never exceeds 9.
- **Load:**
  - `load` = 1, `din` = 6, `enable` = 1 → next `qout` = 6 (not 5), then 5, 4, …
  - `load` = 1, `din` = 13 → `qout` = 9 and a single-cycle `load_err` = 1 pulse.
- **Priority:**
  - `reset` = 1, `load` = 1, `din` = 4 on the same edge → `qout` = 0.
  - `load` with `enable` = 0 → `qout` = `din`, then holds.
- **Enable gap:** count from 7 with `enable` pulsing 1, 0, 0, 1 → `qout` 6, 6, 6, 5; `bout` = 0 throughout.
- **Cascade (2 stages, R = 10):** load both stages with 0, then `enable` = 1 on stage 0 → combined value goes 00, 99, 98, … The upper digit decrements only in cycles where the lower digit = 0.
